// File: rtl/burst_memory_slave.sv
// Burst-capable on-chip memory slave for the shared system bus.
// Serves read bursts with prefetched beats plus an end marker, absorbs write bursts; outputs are zero when idle.
module burst_memory_slave #(
   parameter logic [31:0] baseAddress = 32'h40000000,
   parameter int          nrOfWords   = 1024,
   parameter int          waitStates  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        beginTransactionIn,
   input  logic [31:0] addressDataIn,
   input  logic        readNotWriteIn,
   input  logic [3:0]  byteEnablesIn,
   input  logic [7:0]  burstSizeIn,
   input  logic        dataValidIn,
   input  logic        endTransactionIn,
   input  logic        busErrorIn,
   output logic        dataValidOut,
   output logic [31:0] addressDataOut,
   output logic        endTransactionOut,
   output logic        busErrorOut
);

   localparam int AW = $clog2(nrOfWords);

   typedef enum logic [2:0] {IDLE, WAIT, READ, READ_END, WRITE, ERR_DRAIN} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  wordAddr_q, wordAddr_d;
   logic [8:0]     beatCnt_q, beatCnt_d;
   logic [3:0]     waitCnt_q, waitCnt_d;
   logic [3:0]     be_q, be_d;
   logic           dataValid_q, dataValid_d;
   logic           endOut_q, endOut_d;
   logic           errOut_q, errOut_d;
   logic [31:0]    data_q;

   logic [31:0]    mem [nrOfWords];
   logic [AW-1:0]  rdAddr;
   logic           memWe;

   logic [31:0]    offset;
   logic [AW-1:0]  startWord;
   logic           hit, errDecode, abort;

   // Address window decode; the subtraction wraps below baseAddress so one compare covers both ends.
   always_comb begin
      offset    = addressDataIn - baseAddress;
      hit       = offset < 32'(4 * nrOfWords);
      startWord = offset[AW+1:2];
      errDecode = (offset[1:0] != 2'b00) ||
                  ((32'(startWord) + 32'(burstSizeIn)) >= 32'(nrOfWords));
      abort     = endTransactionIn || busErrorIn;
   end

   always_comb begin
      state_d     = state_q;
      wordAddr_d  = wordAddr_q;
      beatCnt_d   = beatCnt_q;
      waitCnt_d   = waitCnt_q;
      be_d        = be_q;
      dataValid_d = 1'b0;
      endOut_d    = 1'b0;
      errOut_d    = 1'b0;
      rdAddr      = wordAddr_q;
      memWe       = 1'b0;
      case (state_q)
         IDLE: begin
            if (beginTransactionIn && hit) begin
               if (errDecode) begin
                  errOut_d = 1'b1;
                  if (readNotWriteIn) endOut_d = 1'b1;
                  else                state_d  = ERR_DRAIN;
               end else if (readNotWriteIn) begin
                  beatCnt_d  = {1'b0, burstSizeIn};
                  wordAddr_d = startWord;
                  if (waitStates == 0) begin
                     dataValid_d = 1'b1;
                     rdAddr      = startWord;
                     wordAddr_d  = startWord + 1'b1;
                     state_d     = READ;
                  end else begin
                     waitCnt_d = 4'(waitStates - 1);
                     state_d   = WAIT;
                  end
               end else begin
                  wordAddr_d = startWord;
                  beatCnt_d  = {1'b0, burstSizeIn} + 9'd1;
                  be_d       = byteEnablesIn;
                  state_d    = WRITE;
               end
            end
         end
         WAIT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (waitCnt_q == 4'd0) begin
               dataValid_d = 1'b1;
               rdAddr      = wordAddr_q;
               wordAddr_d  = wordAddr_q + 1'b1;
               state_d     = READ;
            end else begin
               waitCnt_d = waitCnt_q - 4'd1;
            end
         end
         READ: begin
            // The beat counter holds the number of beats still to issue after the one on the bus.
            if (abort) begin
               state_d = IDLE;
            end else if (beatCnt_q != 9'd0) begin
               dataValid_d = 1'b1;
               rdAddr      = wordAddr_q;
               wordAddr_d  = wordAddr_q + 1'b1;
               beatCnt_d   = beatCnt_q - 9'd1;
            end else begin
               endOut_d = 1'b1;
               state_d  = READ_END;
            end
         end
         READ_END: state_d = IDLE;
         WRITE: begin
            if (busErrorIn) begin
               state_d = IDLE;
            end else begin
               if (dataValidIn && beatCnt_q != 9'd0) begin
                  memWe      = 1'b1;
                  wordAddr_d = wordAddr_q + 1'b1;
                  beatCnt_d  = beatCnt_q - 9'd1;
               end
               if (endTransactionIn) state_d = IDLE;
            end
         end
         ERR_DRAIN: if (abort) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wordAddr_q  <= '0;
         beatCnt_q   <= '0;
         waitCnt_q   <= '0;
         be_q        <= '0;
         dataValid_q <= 1'b0;
         endOut_q    <= 1'b0;
         errOut_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wordAddr_q  <= wordAddr_d;
         beatCnt_q   <= beatCnt_d;
         waitCnt_q   <= waitCnt_d;
         be_q        <= be_d;
         dataValid_q <= dataValid_d;
         endOut_q    <= endOut_d;
         errOut_q    <= errOut_d;
      end
   end

   // Registered RAM read port; the address is one word ahead so beats come back-to-back.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           data_q <= '0;
      else if (dataValid_d) data_q <= mem[rdAddr];
      else                  data_q <= '0;
   end

   always_ff @(posedge clock) begin
      if (memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[wordAddr_q][8*b +: 8] <= addressDataIn[8*b +: 8];
         end
      end
   end

   assign dataValidOut      = dataValid_q;
   assign addressDataOut    = data_q;
   assign endTransactionOut = endOut_q;
   assign busErrorOut       = errOut_q;

endmodule

// File: tb/tb_burst_memory_slave.sv
// Directed bench for burst_memory_slave: a vector table of bus transactions
// plus hand-written sequences for abort, overflow, error drain and async reset.
module tb_burst_memory_slave;

   localparam logic [31:0] BASE = 32'h40000000;
   localparam int          W    = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        beginTransactionIn, readNotWriteIn, dataValidIn, endTransactionIn, busErrorIn;
   logic [31:0] addressDataIn;
   logic [3:0]  byteEnablesIn;
   logic [7:0]  burstSizeIn;
   logic        dataValidOut, endTransactionOut, busErrorOut;
   logic [31:0] addressDataOut;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] expBeats [16];

   typedef struct {
      logic             isRead;
      logic [31:0]      addr;
      logic [7:0]       burst;
      logic [3:0]       be;
      int               mode;
      int               nBeats;
      logic [15:0][31:0] d;
   } tv_t;

   tv_t vecs [12];

   burst_memory_slave #(.baseAddress(BASE), .nrOfWords(1024), .waitStates(W)) dut (
      .clock(clock), .reset(reset),
      .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
      .readNotWriteIn(readNotWriteIn), .byteEnablesIn(byteEnablesIn),
      .burstSizeIn(burstSizeIn), .dataValidIn(dataValidIn),
      .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
      .dataValidOut(dataValidOut), .addressDataOut(addressDataOut),
      .endTransactionOut(endTransactionOut), .busErrorOut(busErrorOut)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic tv_t mk(input logic isRead, input logic [31:0] addr, input logic [7:0] burst,
                              input logic [3:0] be, input int mode, input int n,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
      tv_t v;
      v.isRead = isRead; v.addr = addr; v.burst = burst; v.be = be;
      v.mode = mode; v.nBeats = n; v.d = '0;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      return v;
   endfunction

   // Expected value packs {dataValidOut, addressDataOut, endTransactionOut, busErrorOut}.
   task automatic checkOutput(input string name, input logic [34:0] expv);
      logic [34:0] act;
      act = {dataValidOut, addressDataOut, endTransactionOut, busErrorOut};
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got dv=%b data=%h end=%b err=%b, expected dv=%b data=%h end=%b err=%b",
                  name, act[34], act[33:2], act[1], act[0], expv[34], expv[33:2], expv[1], expv[0]);
      end
   endtask

   // mode 0: normal burst, 1: error response, 2: no response at all.
   task automatic doRead(input string name, input logic [31:0] addr, input int burst, input int mode);
      int last;
      logic [34:0] e;
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b1;
      addressDataIn = addr; burstSizeIn = 8'(burst); byteEnablesIn = 4'h0;
      @(negedge clock);
      beginTransactionIn = 1'b0; addressDataIn = '0;
      last = (mode == 0) ? W + burst + 3 : 3;
      for (int k = 1; k <= last; k++) begin
         e = '0;
         if (mode == 0) begin
            if (k >= 1 + W && k <= 1 + W + burst) e = {1'b1, expBeats[k-1-W], 2'b00};
            else if (k == 2 + W + burst)          e = {1'b0, 32'h0, 2'b10};
         end else if (mode == 1 && k == 1) begin
            e = {1'b0, 32'h0, 2'b11};
         end
         checkOutput($sformatf("%s cycle %0d", name, k), e);
         @(negedge clock);
      end
   endtask

   task automatic doWrite(input string name, input logic [31:0] addr, input logic [7:0] burst,
                          input logic [3:0] be, input int n, input logic expErr,
                          input logic [15:0][31:0] d);
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b0;
      addressDataIn = addr; burstSizeIn = burst; byteEnablesIn = be;
      @(negedge clock);
      beginTransactionIn = 1'b0;
      checkOutput($sformatf("%s cycle 1", name), {1'b0, 32'h0, 1'b0, expErr});
      for (int i = 0; i < n; i++) begin
         dataValidIn = 1'b1; addressDataIn = d[i]; endTransactionIn = (i == n - 1);
         @(negedge clock);
         checkOutput($sformatf("%s beat %0d", name, i), 35'h0);
      end
      dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
   endtask

   task automatic applyStimulus(input int idx);
      tv_t v;
      v = vecs[idx];
      if (v.isRead) begin
         for (int i = 0; i < 16; i++) expBeats[i] = v.d[i];
         doRead($sformatf("vec%0d read", idx), v.addr, int'(v.burst), v.mode);
      end else begin
         doWrite($sformatf("vec%0d write", idx), v.addr, v.burst, v.be, v.nBeats, v.mode == 1, v.d);
      end
   endtask

   initial begin
      logic [15:0][31:0] wd;
      reset = 1'b0;
      beginTransactionIn = 1'b0; readNotWriteIn = 1'b0; dataValidIn = 1'b0;
      endTransactionIn = 1'b0; busErrorIn = 1'b0;
      addressDataIn = '0; byteEnablesIn = '0; burstSizeIn = '0;

      vecs[0]  = mk(1'b0, BASE + 32'h10,  8'd3, 4'hF, 0, 4, 32'h11, 32'h22, 32'h33, 32'h44);
      vecs[1]  = mk(1'b1, BASE + 32'h10,  8'd3, 4'h0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      vecs[2]  = mk(1'b0, BASE + 32'h100, 8'd0, 4'hF, 0, 1, 32'hAABBCCDD, 0, 0, 0);
      vecs[3]  = mk(1'b0, BASE + 32'h100, 8'd0, 4'h5, 0, 1, 32'h11223344, 0, 0, 0);
      vecs[4]  = mk(1'b1, BASE + 32'h100, 8'd0, 4'h0, 0, 0, 32'hAA22CC44, 0, 0, 0);
      vecs[5]  = mk(1'b1, BASE + 32'h2,   8'd0, 4'h0, 1, 0, 0, 0, 0, 0);
      vecs[6]  = mk(1'b1, BASE + 32'hFFC, 8'd1, 4'h0, 1, 0, 0, 0, 0, 0);
      vecs[7]  = mk(1'b1, BASE - 32'h4,   8'd0, 4'h0, 2, 0, 0, 0, 0, 0);
      vecs[8]  = mk(1'b0, BASE + 32'hFFC, 8'd0, 4'hF, 0, 1, 32'hCAFEF00D, 0, 0, 0);
      vecs[9]  = mk(1'b1, BASE + 32'hFFC, 8'd0, 4'h0, 0, 0, 32'hCAFEF00D, 0, 0, 0);
      vecs[10] = mk(1'b1, BASE + 32'h1000, 8'd0, 4'h0, 2, 0, 0, 0, 0, 0);
      vecs[11] = mk(1'b1, BASE + 32'h14,  8'd1, 4'h0, 0, 0, 32'h22, 32'h33, 0, 0);

      @(negedge clock);
      @(negedge clock);
      checkOutput("reset state", 35'h0);
      reset = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 12; i++) applyStimulus(i);

      // Abort a 16-beat read on its third beat.
      for (int i = 0; i < 16; i++) wd[i] = 32'(i + 1);
      doWrite("abort prefill", BASE + 32'h200, 8'd15, 4'hF, 16, 1'b0, wd);
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b1;
      addressDataIn = BASE + 32'h200; burstSizeIn = 8'd15;
      @(negedge clock);
      beginTransactionIn = 1'b0; addressDataIn = '0;
      for (int k = 1; k <= 5; k++) begin
         checkOutput($sformatf("abort cycle %0d", k),
                     (k >= 3) ? {1'b1, 32'(k - 2), 2'b00} : 35'h0);
         if (k < 5) @(negedge clock);
      end
      endTransactionIn = 1'b1;
      @(negedge clock);
      endTransactionIn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("abort quiet %0d", k), 35'h0);
         @(negedge clock);
      end
      expBeats[0] = 32'h1; expBeats[1] = 32'h2;
      doRead("after abort", BASE + 32'h200, 1, 0);

      // Write overflow: three beats into a two-word burst.
      wd = '0; wd[0] = 32'h99;
      doWrite("overflow guard", BASE + 32'h308, 8'd0, 4'hF, 1, 1'b0, wd);
      wd[0] = 32'h5; wd[1] = 32'h6; wd[2] = 32'h7;
      doWrite("overflow write", BASE + 32'h300, 8'd1, 4'hF, 3, 1'b0, wd);
      expBeats[0] = 32'h5; expBeats[1] = 32'h6; expBeats[2] = 32'h99;
      doRead("overflow read", BASE + 32'h300, 2, 0);

      // Misaligned write drains its data without touching memory.
      wd = '0; wd[0] = 32'hDEAD; wd[1] = 32'hBEEF;
      doWrite("misaligned write", BASE + 32'h302, 8'd0, 4'hF, 2, 1'b1, wd);
      expBeats[0] = 32'h5; expBeats[1] = 32'h6;
      doRead("after drain", BASE + 32'h300, 1, 0);

      // Asynchronous reset between edges in the middle of a read burst.
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b1;
      addressDataIn = BASE + 32'h10; burstSizeIn = 8'd3;
      @(negedge clock);
      beginTransactionIn = 1'b0; addressDataIn = '0;
      repeat (3) @(negedge clock);
      checkOutput("pre-reset beat", {1'b1, 32'h22, 2'b00});
      #2 reset = 1'b0;
      #1 checkOutput("async reset", 35'h0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("post reset idle", 35'h0);
      expBeats[0] = 32'h11; expBeats[1] = 32'h22; expBeats[2] = 32'h33; expBeats[3] = 32'h44;
      doRead("post reset read", BASE + 32'h10, 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
